// File: rtl/dac_pkg.sv
// Shared definitions for the DAC register loader and the DAC polling stage:
// sizes, loader FSM states and the bit layout of a 16-bit host SPI frame.
package dac_pkg;

  localparam int N_CH      = 8;
  localparam int DW        = 12;
  localparam int FRAME_LEN = 16;
  localparam int CNT_W     = 5;

  // Frame layout: write = {0, addr[2:0], data[11:0]}, control = {1, load, en, load0, unused[11:0]}
  localparam int CTRL     = 15;
  localparam int LOAD     = 14;
  localparam int EN       = 13;
  localparam int LOAD0    = 12;
  localparam int ADDR_MSB = 14;
  localparam int ADDR_LSB = 12;
  localparam int DATA_MSB = 11;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK,
    WAIT_CS_HIGH
  } state_t;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] cnt);
    return (cnt == '1) ? cnt : cnt + CNT_W'(1);
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer for one asynchronous host line, plus a third flop
// used to detect rising and falling edges of the synchronized level.
module spi_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_core,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_core or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      prev_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;
  assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/dac_reg_loader.sv
// Receives 16-bit SPI frames from the host, stages channel codes in shadow
// registers and publishes them to the DAC polling stage on a load command.
module dac_reg_loader #(
  parameter int N_CH      = dac_pkg::N_CH,
  parameter int DW        = dac_pkg::DW,
  parameter int FRAME_LEN = dac_pkg::FRAME_LEN
) (
  input  logic          clk_core,
  input  logic          rst,
  input  logic          sck,
  input  logic          cs_n,
  input  logic          mosi,
  output logic [DW-1:0] data_out [0:N_CH-1],
  output logic          dac_en,
  output logic          frame_ok,
  output logic          frame_err
);

  import dac_pkg::*;

  logic sckLevel;
  logic sckRise;
  logic sckFall;
  logic csLevel;
  logic csRise;
  logic csFall;
  logic unusedSck;

  logic mosiMeta_q;
  logic mosiSync_q;

  state_t               state_q;
  logic [FRAME_LEN-1:0] shift_q;
  logic [CNT_W-1:0]     bitCnt_q;
  logic [CNT_W-1:0]     bitCnt_d;
  logic [DW-1:0]        shadow_q [0:N_CH-1];
  logic [DW-1:0]        frameData;

  spi_sync #(.RESET_VAL(1'b0)) u_sckSync (
    .clk_core (clk_core),
    .rst      (rst),
    .d_i      (sck),
    .level_o  (sckLevel),
    .rise_o   (sckRise),
    .fall_o   (sckFall)
  );

  spi_sync #(.RESET_VAL(1'b1)) u_csSync (
    .clk_core (clk_core),
    .rst      (rst),
    .d_i      (cs_n),
    .level_o  (csLevel),
    .rise_o   (csRise),
    .fall_o   (csFall)
  );

  assign unusedSck = sckLevel ^ sckFall;

  // mosi shares the two-flop delay of sck, so it is stable when sckRise fires
  always_ff @(posedge clk_core or posedge rst) begin
    if (rst) begin
      mosiMeta_q <= 1'b0;
      mosiSync_q <= 1'b0;
    end else begin
      mosiMeta_q <= mosi;
      mosiSync_q <= mosiMeta_q;
    end
  end

  always_comb begin
    bitCnt_d  = satInc(bitCnt_q);
    frameData = shift_q[DATA_MSB:0];
  end

  always_ff @(posedge clk_core or posedge rst) begin
    if (rst) begin
      state_q   <= WAIT_CS_HIGH;
      shift_q   <= '0;
      bitCnt_q  <= '0;
      dac_en    <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        shadow_q[i] <= '0;
        data_out[i] <= '0;
      end
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      case (state_q)
        // Synchronizers still hold reset values right after reset, so cs_n must
        // be seen high on three consecutive cycles before trusting it.
        WAIT_CS_HIGH: begin
          if (!csLevel) begin
            bitCnt_q <= '0;
          end else if (bitCnt_q >= CNT_W'(2)) begin
            bitCnt_q <= '0;
            state_q  <= IDLE;
          end else begin
            bitCnt_q <= bitCnt_d;
          end
        end
        IDLE: begin
          if (csFall) begin
            bitCnt_q <= '0;
            shift_q  <= '0;
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          if (sckRise && !csLevel) begin
            shift_q  <= {shift_q[FRAME_LEN-2:0], mosiSync_q};
            bitCnt_q <= bitCnt_d;
          end
          if (csRise) begin
            state_q <= CHECK;
          end
        end
        CHECK: begin
          state_q <= IDLE;
          if (bitCnt_q == CNT_W'(FRAME_LEN)) begin
            frame_ok <= 1'b1;
            if (!shift_q[CTRL]) begin
              shadow_q[shift_q[ADDR_MSB:ADDR_LSB]] <= frameData;
            end else begin
              dac_en <= shift_q[EN];
              if (shift_q[LOAD]) begin
                for (int i = 0; i < N_CH; i++) begin
                  data_out[i] <= (i == 0 && shift_q[LOAD0]) ? frameData : shadow_q[i];
                end
                if (shift_q[LOAD0]) begin
                  shadow_q[0] <= frameData;
                end
              end
            end
          end else begin
            frame_err <= 1'b1;
          end
        end
        default: state_q <= WAIT_CS_HIGH;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_reg_loader.sv
// Self-checking bench for dac_reg_loader: table of directed frames, hand-built
// reset/idle corner sequences and random frames against a word-level model.
module tb_dac_reg_loader;

  localparam int NCH = 8;
  localparam int W   = 12;

  logic          clk_core = 1'b0;
  logic          rst = 1'b0;
  logic          sck = 1'b0;
  logic          cs_n = 1'b1;
  logic          mosi = 1'b0;
  logic [W-1:0]  data_out [0:NCH-1];
  logic          dac_en;
  logic          frame_ok;
  logic          frame_err;

  int testsRun    = 0;
  int testsFailed = 0;
  int okCount     = 0;
  int errCount    = 0;

  logic [11:0] mShadow [0:NCH-1];
  logic [11:0] mData   [0:NCH-1];
  logic        mEn;

  typedef struct {
    logic [31:0] bits;
    int          nbits;
    bit          expOk;
    bit          expErr;
  } vec_t;

  vec_t vecs [0:13];

  dac_reg_loader #(.N_CH(NCH), .DW(W), .FRAME_LEN(16)) dut (
    .clk_core  (clk_core),
    .rst       (rst),
    .sck       (sck),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .data_out  (data_out),
    .dac_en    (dac_en),
    .frame_ok  (frame_ok),
    .frame_err (frame_err)
  );

  always #5 clk_core = ~clk_core;

  // Pulse counters sampled mid-cycle, so a one-cycle pulse counts exactly once
  always @(negedge clk_core) begin
    if (frame_ok)  okCount  <= okCount + 1;
    if (frame_err) errCount <= errCount + 1;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name);
    check({name, " dac_en"}, 32'(dac_en), 32'(mEn));
    for (int i = 0; i < NCH; i++) begin
      check($sformatf("%s data_out[%0d]", name, i), 32'(data_out[i]), 32'(mData[i]));
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk_core);
  endtask

  function automatic void modelReset();
    for (int i = 0; i < NCH; i++) begin
      mShadow[i] = '0;
      mData[i]   = '0;
    end
    mEn = 1'b0;
  endfunction

  // Word-level behaviour: a frame counts only if exactly 16 bits were clocked in
  function automatic void modelFrame(input logic [31:0] v, input int n, output bit ok, output bit err);
    int w;
    ok  = 1'b0;
    err = 1'b0;
    if (n != 16) begin
      err = 1'b1;
      return;
    end
    ok = 1'b1;
    w  = int'(v[15:0]);
    if (w < 32768) begin
      mShadow[(w / 4096) % 8] = 12'(w % 4096);
    end else begin
      mEn = ((w / 8192) % 2) == 1;
      if ((w / 16384) % 2 == 1) begin
        if ((w / 4096) % 2 == 1) mShadow[0] = 12'(w % 4096);
        for (int i = 0; i < NCH; i++) mData[i] = mShadow[i];
      end
    end
  endfunction

  task automatic sendBits(input logic [31:0] bits, input int n);
    for (int b = n - 1; b >= 0; b--) begin
      mosi = bits[b];
      waitCycles(4);
      sck = 1'b1;
      waitCycles(4);
      sck = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [31:0] bits, input int n);
    @(negedge clk_core);
    cs_n = 1'b0;
    waitCycles(4);
    sendBits(bits, n);
    waitCycles(4);
    cs_n = 1'b1;
  endtask

  // Called right after cs_n rises; checks latency, same-cycle outputs and pulse counts
  task automatic finishFrame(input string name, input bit expOk, input bit expErr);
    int ok0;
    int err0;
    int lat;
    ok0 = okCount;
    err0 = errCount;
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk_core);
      #1;
      if (lat == 0 && (frame_ok || frame_err)) begin
        lat = c;
        checkOutput(name);
      end
    end
    if (expOk || expErr) begin
      check({name, " latency<=4"}, 32'(lat >= 1 && lat <= 4), 32'd1);
    end
    waitCycles(4);
    check({name, " frame_ok pulses"}, 32'(okCount - ok0), 32'(expOk));
    check({name, " frame_err pulses"}, 32'(errCount - err0), 32'(expErr));
    if (lat == 0) checkOutput(name);
  endtask

  task automatic runFrame(input string name, input logic [31:0] bits, input int n);
    bit ok;
    bit err;
    modelFrame(bits, n, ok, err);
    applyStimulus(bits, n);
    finishFrame(name, ok, err);
  endtask

  initial begin
    bit ok;
    bit err;
    logic [31:0] v;
    int n;

    vecs[0] = '{32'h3ABC, 16, 1'b1, 1'b0};
    for (int i = 0; i < NCH; i++) begin
      vecs[1 + i] = '{32'((i << 12) | (32'h100 * i + 1)), 16, 1'b1, 1'b0};
    end
    vecs[9]  = '{32'hE000, 16, 1'b1, 1'b0};
    vecs[10] = '{32'h0ABC, 12, 1'b0, 1'b1};
    vecs[11] = '{32'h12345, 17, 1'b0, 1'b1};
    vecs[12] = '{32'hA000, 16, 1'b1, 1'b0};
    vecs[13] = '{32'hD123, 16, 1'b1, 1'b0};

    modelReset();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("reset");
    check("reset frame_ok", 32'(frame_ok), 32'd0);
    check("reset frame_err", 32'(frame_err), 32'd0);
    waitCycles(3);
    rst = 1'b0;
    waitCycles(6);

    for (int k = 0; k < 14; k++) begin
      modelFrame(vecs[k].bits, vecs[k].nbits, ok, err);
      applyStimulus(vecs[k].bits, vecs[k].nbits);
      finishFrame($sformatf("vec%0d", k), vecs[k].expOk, vecs[k].expErr);
    end

    // sck activity with cs_n high must not disturb the next frame
    @(negedge clk_core);
    for (int t = 0; t < 5; t++) begin
      mosi = 1'b1;
      waitCycles(4);
      sck = 1'b1;
      waitCycles(4);
      sck = 1'b0;
    end
    waitCycles(4);
    runFrame("idle-sck 5FFF", 32'h5FFF, 16);
    runFrame("idle-sck load", 32'hC000, 16);

    // cs_n pulse with no sck edges
    @(negedge clk_core);
    cs_n = 1'b0;
    waitCycles(8);
    cs_n = 1'b1;
    finishFrame("zero-bit", 1'b0, 1'b1);

    // reset in the middle of a frame, released with cs_n still low
    runFrame("pre-reset load", 32'hE000, 16);
    @(negedge clk_core);
    cs_n = 1'b0;
    waitCycles(4);
    sendBits(32'h20, 8);
    @(negedge clk_core);
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput("mid-frame reset");
    waitCycles(3);
    rst = 1'b0;
    sendBits(32'h55, 8);
    waitCycles(4);
    cs_n = 1'b1;
    finishFrame("post-reset tail", 1'b0, 1'b0);
    runFrame("post-reset 2055", 32'h2055, 16);
    runFrame("post-reset load", 32'hC000, 16);

    for (int r = 0; r < 40; r++) begin
      v = $urandom;
      n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 20)) : 16;
      if (r % 4 == 3) begin
        v = 32'hC000 | (v & 32'h3FFF);
        n = 16;
      end
      runFrame($sformatf("rand%0d", r), v, n);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
